// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
package div_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } div_state_e;

  localparam int DIV_ITER = 32;
  localparam int CNT_W    = $clog2(DIV_ITER);

endpackage

// File: rtl/div_seq_if.sv
// Request/result bundle between a divider client (master) and div_seq (slave).
interface div_seq_if
  import div_pkg::*;
#(
  parameter int XLEN = 32
) ();

  logic            start;
  div_op_e         op;
  logic [XLEN-1:0] opr_a;
  logic [XLEN-1:0] opr_b;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] opr_res;

  modport master (output start, op, opr_a, opr_b, flush, input busy, done, opr_res);
  modport slave  (input start, op, opr_a, opr_b, flush, output busy, done, opr_res);

endinterface

// File: rtl/div_seq_step.sv
// One restoring shift/subtract iteration; purely combinational.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] quo_i,
  input  logic [W-1:0] dvs_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] quo_o
);

  logic [W:0] sh;
  logic [W:0] diff;

  // Extra top bit catches both the shifted-out remainder bit and the borrow.
  always_comb begin
    sh    = {rem_i, quo_i[W-1]};
    diff  = sh - {1'b0, dvs_i};
    rem_o = sh[W-1:0];
    quo_o = {quo_i[W-2:0], 1'b0};
    if (!diff[W]) begin
      rem_o = diff[W-1:0];
      quo_o = {quo_i[W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_seq.sv
// Sequential 32-bit DIV/DIVU/REM/REMU: 34-cycle latency, start ignored while busy; flush aborts.
// DIV_FASTPATH_EN: divide-by-zero and signed overflow skip CALC/FIX and finish in 1 cycle.
module div_seq
  import div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic       clk,
  input  logic       rst,
  div_seq_if.slave   bus
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e       state_q, state_d;
  div_op_e          op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [XLEN-1:0]  dnd_q, dnd_d, res_q, res_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d;
  logic             dz_q, dz_d, ovf_q, ovf_d;

  logic             in_signed, a_neg, b_neg, in_dz, in_ovf, is_rem;
  logic [XLEN-1:0]  step_rem, step_quo;

  function automatic logic [XLEN-1:0] special_res(input logic rem, input logic dz,
                                                  input logic [XLEN-1:0] dnd);
    if (dz) return rem ? dnd : '1;
    return rem ? '0 : MIN_NEG;
  endfunction

  div_step #(.W(XLEN)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  assign in_signed = (bus.op == DIV) || (bus.op == REM);
  assign a_neg     = in_signed && bus.opr_a[XLEN-1];
  assign b_neg     = in_signed && bus.opr_b[XLEN-1];
  assign in_dz     = (bus.opr_b == '0);
  assign in_ovf    = in_signed && (bus.opr_a == MIN_NEG) && (bus.opr_b == '1);
  assign is_rem    = (op_q == REM) || (op_q == REMU);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    dnd_d   = dnd_q;
    res_d   = res_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d    = bus.op;
          dnd_d   = bus.opr_a;
          dz_d    = in_dz;
          ovf_d   = in_ovf;
          qneg_d  = a_neg ^ b_neg;
          rneg_d  = a_neg;
          rem_d   = '0;
          quo_d   = a_neg ? -bus.opr_a : bus.opr_a;
          dvs_d   = b_neg ? -bus.opr_b : bus.opr_b;
          cnt_d   = '0;
          state_d = CALC;
`ifdef DIV_FASTPATH_EN
          if (in_dz || in_ovf) begin
            res_d   = special_res((bus.op == REM) || (bus.op == REMU), in_dz, bus.opr_a);
            state_d = DONE;
          end
`endif
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DIV_ITER - 1)) state_d = FIX;
      end
      FIX: begin
        if (dz_q || ovf_q) res_d = special_res(is_rem, dz_q, dnd_q);
        else if (is_rem)   res_d = rneg_q ? -rem_q : rem_q;
        else               res_d = qneg_q ? -quo_q : quo_q;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort wins over everything, including a result about to be loaded.
    if (bus.flush) begin
      state_d = IDLE;
      res_d   = res_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= DIV;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      dnd_q   <= '0;
      res_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      dnd_q   <= dnd_d;
      res_q   <= res_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == DONE);
  assign bus.opr_res = res_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: arithmetic, latency, DONE-cycle start, flush, busy start and reset abort.
module tb_div_seq;
  import div_pkg::*;

`ifdef DIV_FASTPATH_EN
  localparam int SP_LAT = 1;
`else
  localparam int SP_LAT = 34;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_bad = 0;

  div_seq_if bus ();

  div_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one operation, measure edges from the sampling edge (counted as 1) to done,
  // then drive start during the DONE cycle and confirm it is dropped.
  task automatic run_op(input string tag, input div_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    @(negedge clk);
    bus.op = op; bus.opr_a = a; bus.opr_b = b; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_res"}, bus.opr_res, exp_res);
    bus.op = DIVU; bus.opr_a = 32'd1; bus.opr_b = 32'd1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({tag, "_done_start_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    int cyc;
    int ndone;
    int first_lat;

    bus.start = 1'b0; bus.flush = 1'b0; bus.op = DIVU;
    bus.opr_a = '0; bus.opr_b = '0;
    rst = 1'b1;
    #1;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_res", bus.opr_res, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_op("divu_100_7", DIVU, 32'd100, 32'd7, 32'd14, 34);
    run_op("remu_100_7", REMU, 32'd100, 32'd7, 32'd2, 34);
    run_op("div_m100_7", DIV, -32'sd100, 32'd7, 32'hFFFF_FFF2, 34);
    run_op("rem_m100_7", REM, -32'sd100, 32'd7, 32'hFFFF_FFFE, 34);
    run_op("div_7_m2", DIV, 32'd7, -32'sd2, 32'hFFFF_FFFD, 34);
    run_op("rem_7_m2", REM, 32'd7, -32'sd2, 32'd1, 34);
    run_op("divu_max_1", DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34);
    run_op("divu_5_0", DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, SP_LAT);
    run_op("remu_5_0", REMU, 32'd5, 32'd0, 32'd5, SP_LAT);
    run_op("div_m5_0", DIV, -32'sd5, 32'd0, 32'hFFFF_FFFF, SP_LAT);
    run_op("rem_m5_0", REM, -32'sd5, 32'd0, 32'hFFFF_FFFB, SP_LAT);
    run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SP_LAT);
    run_op("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, SP_LAT);
    run_op("divu_7_3", DIVU, 32'd7, 32'd3, 32'd2, 34);

    // Flush during CALC cycle 10: result register keeps 2 from the previous op.
    @(negedge clk);
    bus.op = DIVU; bus.opr_a = 32'd50; bus.opr_b = 32'd5; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    chk("flush_pre_busy", {31'd0, bus.busy}, 32'd1);
    bus.flush = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.start = 1'b0;
    chk("flush_busy", {31'd0, bus.busy}, 32'd0);
    chk("flush_res", bus.opr_res, 32'd2);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    chk("flush_no_done", ndone, 32'd0);
    chk("flush_res_hold", bus.opr_res, 32'd2);

    // Second start pulse during CALC must be ignored.
    @(negedge clk);
    bus.op = DIVU; bus.opr_a = 32'd9; bus.opr_b = 32'd3; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.opr_a = 32'd100; bus.opr_b = 32'd7;
    cyc = 1; ndone = 0; first_lat = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      cyc++;
      bus.start = (cyc == 5);
      if (bus.done) begin
        ndone++;
        if (first_lat == 0) first_lat = cyc;
      end
    end
    bus.start = 1'b0;
    chk("busy_start_ndone", ndone, 32'd1);
    chk("busy_start_lat", first_lat, 32'd34);
    chk("busy_start_res", bus.opr_res, 32'd3);

    // Reset in CALC cycle 5 clears outputs immediately and discards the op.
    @(negedge clk);
    bus.op = DIVU; bus.opr_a = 32'd9; bus.opr_b = 32'd3; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, bus.busy}, 32'd0);
    chk("arst_res", bus.opr_res, 32'd0);
    chk("arst_done", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    chk("arst_no_done", ndone, 32'd0);
    chk("arst_idle", {31'd0, bus.busy}, 32'd0);

    run_op("post_rst_divu", DIVU, 32'd100, 32'd7, 32'd14, 34);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
